instr_fetch_queue: RTL

Upstream instruction-fetch stage for the multicycle CPU core.
- Generates sequential PCs and issues word reads to the instruction memory port.
- Buffers the returned {pc, instruction} pairs in a small queue.
- Presents them to decode over a valid/ready handshake.
- On a taken branch or jump, a redirect from the PC-update logic flushes the queue and restarts fetch at the new PC.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/instr_fetch_queue_if.sv | 40 ++++
 rtl/inst_fifo.sv | 62 ++++++
 rtl/instr_fetch_queue.sv | 91 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// Holds the queue entry layout and PC stepping.
package cpu_pkg;

   localparam int          INSTR_W  = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_INC   = 32'd4;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch bus: imem request/response, redirect and decode handshake.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_queue_if
   import cpu_pkg::*;
#(
   parameter int DATA_W = INSTR_W
);

   logic              imem_req;
   logic [31:0]       imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst_data;
   logic [31:0]       inst_pc;
   logic              fetch_err;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  redirect_valid, redirect_pc,
      output inst_valid, inst_data, inst_pc,
      input  inst_ready,
      output fetch_err
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      output redirect_valid, redirect_pc,
      input  inst_valid, inst_data, inst_pc,
      output inst_ready,
      input  fetch_err
   );

endinterface

// File: rtl/inst_fifo.sv
// Circular buffer of fetched {pc, instr} entries.
// Flush wins over push/pop; caller never pushes full or pops empty.
module inst_fifo
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wdata_i,
   output fetch_entry_t head_o,
   output logic [AW:0]  count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + 1'b1;
         if (pop_i)  rd_d = rd_q + 1'b1;
         unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (nreset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: sequential PC issue, one-cycle imem response,
// credit-limited queue to decode, redirect flush, sticky error.
module instr_fetch_queue
   import cpu_pkg::fetch_entry_t;
   import cpu_pkg::PC_INC;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter int          INSTR_W  = cpu_pkg::INSTR_W
) (
   input logic                 clk,
   input logic                 nreset,
   instr_fetch_queue_if.master bus
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic         pending_q, pending_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   logic         err_q, err_d;

   logic [AW:0]   count;
   logic [AW+1:0] inflight;
   logic          credit_ok;
   logic          req, gnt_fire;
   logic          push, pop, flush;
   logic          valid;
   logic [INSTR_W-1:0] rdata;
   fetch_entry_t  wdata, head;

   // queued + in-flight words never exceed DEPTH, so a response always fits
   assign inflight  = {1'b0, count} + {{(AW+1){1'b0}}, pending_q};
   assign credit_ok = inflight < (AW+2)'(DEPTH);
   assign req       = !nreset && !bus.redirect_valid && credit_ok;
   assign gnt_fire  = req && bus.imem_gnt;

   assign valid = !nreset && (count != '0);
   assign push  = bus.imem_rvalid && pending_q && !bus.redirect_valid;
   assign pop   = valid && bus.inst_ready && !bus.redirect_valid;
   assign flush = bus.redirect_valid;

   assign rdata = bus.imem_rdata;
   assign wdata = '{pc: pend_pc_q, instr: rdata};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (bus.redirect_valid)
         fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      else if (gnt_fire)
         fetch_pc_d = fetch_pc_q + PC_INC;
      pending_d = gnt_fire;
      pend_pc_d = gnt_fire ? fetch_pc_q : pend_pc_q;
      err_d     = err_q || (bus.imem_rvalid ^ pending_q);
   end

   always_ff @(posedge clk) begin
      if (nreset) begin
         fetch_pc_q <= RESET_PC;
         pending_q  <= 1'b0;
         pend_pc_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pending_q  <= pending_d;
         pend_pc_q  <= pend_pc_d;
         err_q      <= err_d;
      end
   end

   inst_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .nreset  (nreset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (wdata),
      .head_o  (head),
      .count_o (count)
   );

   assign bus.imem_req   = req;
   assign bus.imem_addr  = fetch_pc_q;
   assign bus.inst_valid = valid;
   assign bus.inst_data  = head.instr;
   assign bus.inst_pc    = head.pc;
   assign bus.fetch_err  = err_q;

endmodule
